// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle MIPS main control FSM sequencing ALU, register file and unified memory
`timescale 1ns/1ps
module mc_main_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic [1:0] RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic [3:0] state_o,
  output logic       err_o
);
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4, MEM_WR = 4'd5,
    R_EXE = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, I_EXE = 4'd10, I_WB = 4'd11,
    JAL = 4'd12, HALT = 4'd13
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
  state_t        state, state_nxt;
  ctrl_t         c;
  logic [CW-1:0] wait_cnt;
  logic          mem_state, timeout, illegal, unused_zero;
  assign unused_zero = zero_i;
  assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeout = mem_state && !mem_ready_i && (wait_cnt == CW'(MEM_TIMEOUT - 1));
  assign illegal = (state == DECODE) &&
                   !(opcode_i inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_SLTI});
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= FETCH;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (mem_state && !mem_ready_i && state_nxt == state) ? wait_cnt + 1'b1 : '0;
      err_o    <= err_o | timeout | illegal;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    state_nxt = mem_ready_i ? DECODE : timeout ? HALT : FETCH;
      DECODE:   case (opcode_i)
                  OP_R:            state_nxt = R_EXE;
                  OP_LW, OP_SW:    state_nxt = MEM_ADDR;
                  OP_BEQ:          state_nxt = BRANCH;
                  OP_J:            state_nxt = JUMP;
                  OP_JAL:          state_nxt = JAL;
                  OP_ADDI, OP_SLTI: state_nxt = I_EXE;
                  default:         state_nxt = HALT;
                endcase
      MEM_ADDR: state_nxt = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   state_nxt = mem_ready_i ? MEM_WB : timeout ? HALT : MEM_RD;
      MEM_WR:   state_nxt = mem_ready_i ? FETCH : timeout ? HALT : MEM_WR;
      R_EXE:    state_nxt = R_WB;
      I_EXE:    state_nxt = I_WB;
      HALT:     state_nxt = HALT;
      default:  state_nxt = FETCH;
    endcase
  end
  always_comb begin
    c = '0;
    case (state)
      FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mem_ready_i; c.pc_write = mem_ready_i; end
      DECODE:   c.alu_src_b = 2'b11;
      MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEM_RD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEM_WB:   begin c.memto_reg = 1'b1; c.reg_write = 1'b1; end
      MEM_WR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      R_EXE:    begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
      R_WB:     begin c.reg_dst = 2'b01; c.reg_write = 1'b1; end
      BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      I_EXE:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = (opcode_i == OP_SLTI) ? 3'b011 : 3'b000; end
      I_WB:     c.reg_write = 1'b1;
      JAL:      begin c.reg_dst = 2'b10; c.reg_write = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default:  c = '0;
    endcase
  end
  // reset masks every control combinationally so nothing partial escapes mid-instruction
  assign {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegDst_o,
          RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o} = rst_i ? '0 : c;
  assign state_o = state;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: randomized instruction stream against a phase-sequence model with a per-cycle scoreboard
`timescale 1ns/1ps
module tb_mc_main_ctrl;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  logic       clk_i = 1'b0, rst_i = 1'b1, zero_i = 1'b0, mem_ready_i = 1'b0;
  logic [5:0] opcode_i = '0;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o;
  logic       RegWrite_o, ALUSrcA_o, err_o;
  logic [1:0] RegDst_o, ALUSrcB_o, PCSource_o;
  logic [2:0] ALUOp_o;
  logic [3:0] state_o;
  logic [22:0] exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  logic err_m = 1'b0;
  mc_main_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o), .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o),
    .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .PCSource_o(PCSource_o), .state_o(state_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction
  // control word expected in each phase, straight from the phase description table
  function automatic logic [17:0] exp_ctl(input int st, input logic rdy, input logic [5:0] op);
    logic pcw, pcc, iord, mr, mw, irw, m2r, rw, asa;
    logic [1:0] rd, asb, pcs;
    logic [2:0] aop;
    {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs} = '0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 3'b010; end
      7:  begin rd = 2'b01; rw = 1; end
      8:  begin asa = 1; aop = 3'b001; pcc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; aop = (op == OP_SLTI) ? 3'b011 : 3'b000; end
      11: rw = 1;
      12: begin rd = 2'b10; rw = 1; pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction
  task automatic step(input logic rdy, input int st);
    mem_ready_i = rdy;
    zero_i = rb();
    exp_q.push_back({4'(st), rst_i ? 18'd0 : exp_ctl(st, rdy, opcode_i), err_m});
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset(input int cur_st);
    rst_i = 1'b1;
    step(rb(), cur_st);
    err_m = 1'b0;
    step(rb(), 0);
    rst_i = 1'b0;
  endtask
  // an instruction is a phase list whose length follows the latency rules plus the memory waits
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    opcode_i = op;
    for (int i = 0; i < fw; i++) step(1'b0, 0);
    step(1'b1, 0);
    step(rb(), 1);
    case (op)
      OP_R:    begin step(rb(), 6); step(rb(), 7); end
      OP_LW:   begin step(rb(), 2); for (int i = 0; i < mw; i++) step(1'b0, 3); step(1'b1, 3); step(rb(), 4); end
      OP_SW:   begin step(rb(), 2); for (int i = 0; i < mw; i++) step(1'b0, 5); step(1'b1, 5); end
      OP_BEQ:  step(rb(), 8);
      OP_J:    step(rb(), 9);
      OP_JAL:  step(rb(), 12);
      OP_ADDI, OP_SLTI: begin step(rb(), 10); step(rb(), 11); end
      default: begin err_m = 1'b1; for (int i = 0; i < 4; i++) step(rb(), 13); end
    endcase
  endtask
  always @(negedge clk_i) begin
    logic [22:0] e, a;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state_o, PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o,
           RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o, err_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl_cycle%0d state/ctl/err got st=%0d ctl=%b err=%b expected st=%0d ctl=%b err=%b",
                 cyc, a[22:19], a[18:1], a[0], e[22:19], e[18:1], e[0]);
      end
    end
  end
  initial begin
    logic [5:0] ops [8];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_SLTI};
    @(posedge clk_i);
    #1;
    step(1'b1, 0);
    rst_i = 1'b0;
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_BEQ, 1, 0);
    run_instr(OP_JAL, 0, 0);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_SLTI, 0, 0);
    run_instr(OP_J, 0, 0);
    for (int n = 0; n < 40; n++) run_instr(ops[$urandom_range(7, 0)], $urandom_range(3, 0), $urandom_range(3, 0));
    run_instr(OP_R, 15, 0);
    run_instr(OP_LW, 0, 15);
    opcode_i = OP_SW;
    step(1'b1, 0);
    step(rb(), 1);
    step(rb(), 2);
    step(1'b0, 5);
    step(1'b0, 5);
    do_reset(5);
    run_instr(OP_JAL, 1, 0);
    run_instr(6'b111111, 0, 0);
    do_reset(13);
    for (int i = 0; i < 16; i++) step(1'b0, 0);
    err_m = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 13);
    do_reset(13);
    opcode_i = OP_LW;
    step(1'b1, 0);
    step(rb(), 1);
    step(rb(), 2);
    for (int i = 0; i < 16; i++) step(1'b0, 3);
    err_m = 1'b1;
    step(1'b1, 13);
    step(rb(), 13);
    do_reset(13);
    run_instr(OP_ADDI, 0, 0);
    @(negedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
